dcache_mem_bridge: RTL and testbench
====================================

# dcache_mem_bridge

Memory-side responder for the data cache's refill/writeback and uncached-access ports. It accepts one transaction at a time:
- 128-bit line read (refill)
- 128-bit line write (dirty writeback)
- 32-bit uncached read or write

It serialises each transaction onto a single 32-bit request/acknowledge memory port and returns read data or completion to the cache. It sits between the data cache and the memory/peripheral interconnect.

## Interface
- ACK_TIMEOUT, 0, max cycles to wait for `mem_ack` per beat; 0 disables the timeout.
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cpu_ren  in  1  line-read request, one-cycle pulse
- cpu_raddr  in  32  line-read address; bits [3:0] ignored
- cpu_wen  in  4  line-write request; any nonzero value is a one-cycle request
- cpu_waddr  in  32  line-write address; bits [3:0] ignored
- cpu_wdata  in  128  line-write data; word k is bits [32k+31:32k]
- dev_rrdy  out  1  bridge can accept a read (line or uncached)
- dev_wrdy  out  1  bridge can accept a write (line or uncached)
- dev_rvalid  out  1  one-cycle pulse; `dev_rdata` valid
- dev_rdata  out  128  refill line
- uncache_ren  in  1  uncached read, level request
- uncache_raddr  in  32  uncached read address
- uncache_rvalid  out  1  one-cycle pulse; `uncache_rdata` valid
- uncache_rdata  out  32  uncached read data
- uncache_wen  in  4  uncached write byte enables, level request when nonzero
- uncache_waddr  in  32  uncached write address
- uncache_wdata  in  32  uncached write data
- uncache_write_finish  out  1  one-cycle pulse; uncached write done
- mem_req  out  1  memory beat request, held until acked
- mem_wstrb  out  4  byte strobes; 0 means read
- mem_addr  out  32  beat address
- mem_wdata  out  32  beat write data
- mem_ack  in  1  beat accepted/completed this cycle
- mem_rdata  in  32  read data, valid with `mem_ack`
- bus_err  out  1  sticky flag: a beat timed out; cleared only by reset

## Operation
- Reset values:
  - `dev_rrdy`, `dev_wrdy`: 1
  - all other outputs: 0, including `dev_rdata`, `uncache_rdata` and `bus_err`
- Both ready outputs are 1 only in IDLE.
- States:
  - IDLE
  - LRD: line read, 4 beats
  - LWR: line write, 4 beats
  - URD: uncached read, 1 beat
  - UWR: uncached write, 1 beat
  - RESP
- IDLE acceptance priority: `cpu_wen != 0` > `cpu_ren` > `uncache_wen != 0` > `uncache_ren`. Lower-priority requests present in the same cycle are ignored; requesters retry.
- On accept, latch into internal registers:
  - line transactions: address with bits [3:0] forced to 0
  - line writes: `cpu_wdata`
  - uncached transactions: `uncache_*` address, data and strobes
- Line beats, k = 0..3 in order:
  - `mem_addr` = {addr[31:4], k[1:0], 2'b00}
  - LWR: `mem_wstrb` = 4'b1111, `mem_wdata` = latched word k
  - LRD: `mem_wstrb` = 0; `mem_rdata` is written to `dev_rdata[32k+31:32k]` on ack
- URD: `mem_wstrb` = 0; `mem_rdata` is captured into `uncache_rdata`.
- UWR: `mem_wstrb` = latched `uncache_wen`, `mem_wdata` = latched `uncache_wdata`.
- Exit from each state:
  - LRD, URD, UWR: go to RESP after the final ack.
  - LWR: return directly to IDLE after beat 3 ack. No completion is signalled to the cache.
  - RESP (1 cycle): pulse `dev_rvalid` (LRD), `uncache_rvalid` (URD) or `uncache_write_finish` (UWR), then go to IDLE.
- `dev_rrdy` and `dev_wrdy` are low in RESP. A level uncached request that is still high during its own response cycle is therefore not re-accepted.
- Timeout (`ACK_TIMEOUT` > 0):
  - A per-beat counter counts cycles with `mem_req` high and `mem_ack` low.
  - On reaching `ACK_TIMEOUT`, the beat completes as if acked, with read data 32'hDEADBEEF.
  - `bus_err` is set, `mem_req` drops for one cycle, and the transaction continues.
  - The counter clears at each beat start.

## Timing
- `mem_req` is registered. It rises the cycle after accept and stays high across consecutive beats. `mem_addr`, `mem_wstrb` and `mem_wdata` advance on the edge where `mem_ack` is sampled.
- With zero-wait ack (`mem_ack` high whenever `mem_req` is high), counting the accept edge as cycle 0:
  - Line read: beats in cycles 1-4, `dev_rvalid` in cycle 5, ready again in cycle 6.
  - Line write: ready again in cycle 5.
  - Uncached access: beat in cycle 1, response in cycle 2, ready in cycle 3.
- Each wait state on `mem_ack` adds exactly one cycle.
- `dev_rdata` and `uncache_rdata` hold their value until the next read of the same type completes.
- `mem_ack` while `mem_req` is low is ignored.
- Asserting `rst` mid-transaction drops `mem_req` immediately (asynchronous) and discards the partial transaction. No response pulse is issued after reset.

## Test plan
- Line read at 0x1000_0048, memory returns word = address, zero wait → beat addresses 0x1000_0040/44/48/4C; `dev_rdata` = {0x1000004C, 0x10000048, 0x10000044, 0x10000040}; `dev_rvalid` exactly in cycle 5.
- Line write at 0x2000_0010, `cpu_wdata` = {D,C,B,A}, ack after 2 waits per beat → `mem_wdata` A,B,C,D with strobes 1111; `dev_wrdy` low for 12 cycles, then high.
- Uncached write 0xBFAF_8000, `uncache_wen` = 4'b0011, data 0x1234_5678, held level → exactly one memory beat; one `uncache_write_finish` pulse; no second beat issued during RESP.
- `cpu_wen` = 1111 and `cpu_ren` asserted in the same IDLE cycle → write accepted first; read request ignored (not queued); the next `cpu_ren` after ready returns is served.
- `ACK_TIMEOUT` = 8, `mem_ack` never asserted during uncached read → `uncache_rdata` = 0xDEADBEEF; `bus_err` = 1 and stays 1 across the following transactions.
- `rst` low during beat 2 of a line read → `mem_req` drops immediately; after release `dev_rrdy` = 1 and no `dev_rvalid` appears.

Source files
------------

// File: rtl/dcache_mem_bridge.sv
// dcache_mem_bridge: serialises cache line/uncached transactions onto a 32-bit req/ack memory port.
// One transaction at a time; 4 beats per line, 1 per uncached access; readies are high only in IDLE.
module dcache_mem_bridge #(
  parameter int ACK_TIMEOUT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_ren,
  input  logic [31:0]  cpu_raddr,
  input  logic [3:0]   cpu_wen,
  input  logic [31:0]  cpu_waddr,
  input  logic [127:0] cpu_wdata,
  output logic         dev_rrdy,
  output logic         dev_wrdy,
  output logic         dev_rvalid,
  output logic [127:0] dev_rdata,
  input  logic         uncache_ren,
  input  logic [31:0]  uncache_raddr,
  output logic         uncache_rvalid,
  output logic [31:0]  uncache_rdata,
  input  logic [3:0]   uncache_wen,
  input  logic [31:0]  uncache_waddr,
  input  logic [31:0]  uncache_wdata,
  output logic         uncache_write_finish,
  output logic         mem_req,
  output logic [3:0]   mem_wstrb,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic         bus_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LRD  = 3'd1,
    S_LWR  = 3'd2,
    S_URD  = 3'd3,
    S_UWR  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  localparam logic [31:0] TMO_LAST = (ACK_TIMEOUT > 0) ? 32'(ACK_TIMEOUT - 1) : 32'd0;
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

  state_t         state_q, state_d;
  state_t         kind_q;
  logic [31:0]    addr_q;
  logic [127:0]   wdata_q;
  logic [3:0]     ustrb_q;
  logic [1:0]     beat_q;
  logic [31:0]    cnt_q;
  logic           mem_req_q;
  logic [127:0]   dev_rdata_q;
  logic [31:0]    unc_rdata_q;
  logic           bus_err_q;

  logic           in_beat;
  logic           is_line;
  logic           beat_last;
  logic           tmo;
  logic           beat_done;
  logic [31:0]    rdata_eff;

  always_comb begin
    in_beat   = (state_q == S_LRD) || (state_q == S_LWR) ||
                (state_q == S_URD) || (state_q == S_UWR);
    is_line   = (kind_q == S_LRD) || (kind_q == S_LWR);
    beat_last = is_line ? (beat_q == 2'd3) : 1'b1;
    // A timed-out beat is retired exactly like an ack, carrying poison data.
    tmo       = (ACK_TIMEOUT > 0) && in_beat && mem_req_q && !mem_ack && (cnt_q == TMO_LAST);
    beat_done = in_beat && mem_req_q && (mem_ack || tmo);
    rdata_eff = tmo ? BAD_DATA : mem_rdata;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_wen != 4'd0)          state_d = S_LWR;
        else if (cpu_ren)             state_d = S_LRD;
        else if (uncache_wen != 4'd0) state_d = S_UWR;
        else if (uncache_ren)         state_d = S_URD;
      end
      S_LRD:   if (beat_done && beat_last) state_d = S_RESP;
      S_LWR:   if (beat_done && beat_last) state_d = S_IDLE;
      S_URD:   if (beat_done)              state_d = S_RESP;
      S_UWR:   if (beat_done)              state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    dev_rrdy             = (state_q == S_IDLE);
    dev_wrdy             = (state_q == S_IDLE);
    dev_rvalid           = (state_q == S_RESP) && (kind_q == S_LRD);
    uncache_rvalid       = (state_q == S_RESP) && (kind_q == S_URD);
    uncache_write_finish = (state_q == S_RESP) && (kind_q == S_UWR);
    dev_rdata            = dev_rdata_q;
    uncache_rdata        = unc_rdata_q;
    bus_err              = bus_err_q;
    mem_req              = mem_req_q;
    mem_addr             = is_line ? {addr_q[31:4], beat_q, 2'b00} : addr_q;
    mem_wstrb            = 4'd0;
    mem_wdata            = 32'd0;
    if (kind_q == S_LWR) begin
      mem_wstrb = 4'b1111;
      mem_wdata = wdata_q[32*beat_q +: 32];
    end else if (kind_q == S_UWR) begin
      mem_wstrb = ustrb_q;
      mem_wdata = wdata_q[31:0];
    end
  end

  // Transaction capture, beat sequencing and read-data return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kind_q      <= S_IDLE;
      addr_q      <= 32'd0;
      wdata_q     <= 128'd0;
      ustrb_q     <= 4'd0;
      beat_q      <= 2'd0;
      cnt_q       <= 32'd0;
      mem_req_q   <= 1'b0;
      dev_rdata_q <= 128'd0;
      unc_rdata_q <= 32'd0;
      bus_err_q   <= 1'b0;
    end else if (state_q == S_IDLE) begin
      if (state_d != S_IDLE) begin
        kind_q    <= state_d;
        mem_req_q <= 1'b1;
        beat_q    <= 2'd0;
        cnt_q     <= 32'd0;
        case (state_d)
          S_LWR: begin
            addr_q  <= cpu_waddr & ~32'hF;
            wdata_q <= cpu_wdata;
          end
          S_LRD:   addr_q <= cpu_raddr & ~32'hF;
          S_UWR: begin
            addr_q  <= uncache_waddr;
            wdata_q <= {96'd0, uncache_wdata};
            ustrb_q <= uncache_wen;
          end
          default: addr_q <= uncache_raddr;
        endcase
      end
    end else if (in_beat) begin
      if (beat_done) begin
        beat_q    <= beat_q + 2'd1;
        cnt_q     <= 32'd0;
        mem_req_q <= !beat_last && !tmo;
        if (state_q == S_LRD) dev_rdata_q[32*beat_q +: 32] <= rdata_eff;
        if (state_q == S_URD) unc_rdata_q <= rdata_eff;
        if (tmo)              bus_err_q   <= 1'b1;
      end else if (mem_req_q) begin
        cnt_q <= cnt_q + 32'd1;
      end else begin
        // One idle cycle after a timed-out beat, then the next beat starts.
        mem_req_q <= 1'b1;
        cnt_q     <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Directed bench for dcache_mem_bridge with a wait-state-programmable memory responder.
module tb_dcache_mem_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_ren;
  logic [31:0]  cpu_raddr;
  logic [3:0]   cpu_wen;
  logic [31:0]  cpu_waddr;
  logic [127:0] cpu_wdata;
  logic         dev_rrdy, dev_wrdy, dev_rvalid;
  logic [127:0] dev_rdata;
  logic         uncache_ren;
  logic [31:0]  uncache_raddr;
  logic         uncache_rvalid;
  logic [31:0]  uncache_rdata;
  logic [3:0]   uncache_wen;
  logic [31:0]  uncache_waddr, uncache_wdata;
  logic         uncache_write_finish;
  logic         mem_req;
  logic [3:0]   mem_wstrb;
  logic [31:0]  mem_addr, mem_wdata;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         bus_err;

  int tests = 0;
  int fails = 0;

  int ack_wait = 0;
  bit ack_en   = 1'b1;
  int wcnt     = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic [3:0]  log_strb[$];

  dcache_mem_bridge #(.ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr),
    .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
    .dev_rrdy(dev_rrdy), .dev_wrdy(dev_wrdy),
    .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
    .uncache_ren(uncache_ren), .uncache_raddr(uncache_raddr),
    .uncache_rvalid(uncache_rvalid), .uncache_rdata(uncache_rdata),
    .uncache_wen(uncache_wen), .uncache_waddr(uncache_waddr), .uncache_wdata(uncache_wdata),
    .uncache_write_finish(uncache_write_finish),
    .mem_req(mem_req), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Memory responder: acks after ack_wait wait cycles, returns word = address.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (mem_req && ack_en) begin
        if (wcnt >= ack_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_addr;
          log_addr.push_back(mem_addr);
          log_wdata.push_back(mem_wdata);
          log_strb.push_back(mem_wstrb);
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt    = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_wdata.delete();
    log_strb.delete();
  endtask

  int pulses, pulse_cyc, lowcnt, reqcnt;

  initial begin
    rst = 1'b0;
    cpu_ren = 1'b0; cpu_raddr = '0; cpu_wen = '0; cpu_waddr = '0; cpu_wdata = '0;
    uncache_ren = 1'b0; uncache_raddr = '0;
    uncache_wen = '0; uncache_waddr = '0; uncache_wdata = '0;
    step();
    step();
    rst = 1'b1;
    step();

    // Reset values
    chk("rst_rrdy",  dev_rrdy, 1);
    chk("rst_wrdy",  dev_wrdy, 1);
    chk("rst_req",   mem_req, 0);
    chk("rst_rdata", dev_rdata, 0);
    chk("rst_urdat", uncache_rdata, 0);
    chk("rst_err",   bus_err, 0);
    chk("rst_rvld",  dev_rvalid, 0);

    // Line read, zero wait
    clear_log();
    ack_wait  = 0;
    cpu_raddr = 32'h1000_0048;
    cpu_ren   = 1'b1;
    pulses = 0; pulse_cyc = -1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) begin
        cpu_ren = 1'b0;
        chk("lrd_req_c1", mem_req, 1);
        chk("lrd_rrdy_c1", dev_rrdy, 0);
      end
      if (dev_rvalid) begin pulses++; pulse_cyc = c; end
      if (c == 5) chk("lrd_rdata", dev_rdata, 128'h1000004C_10000048_10000044_10000040);
      if (c == 6) chk("lrd_rrdy_c6", dev_rrdy, 1);
    end
    chk("lrd_rvld_cnt", pulses, 1);
    chk("lrd_rvld_cyc", pulse_cyc, 5);
    chk("lrd_beats", log_addr.size(), 4);
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      chk("lrd_addr", log_addr[k], 32'h1000_0040 + 32'(4 * k));
      chk("lrd_strb", log_strb[k], 0);
    end

    // Line write, two wait states per beat
    clear_log();
    ack_wait  = 2;
    cpu_waddr = 32'h2000_0010;
    cpu_wdata = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;
    cpu_wen   = 4'hF;
    lowcnt = 0;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) cpu_wen = 4'h0;
      if (!dev_wrdy) lowcnt++;
      if (c == 13) chk("lwr_wrdy_c13", dev_wrdy, 1);
    end
    chk("lwr_wrdy_low", lowcnt, 12);
    chk("lwr_beats", log_addr.size(), 4);
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      chk("lwr_addr",  log_addr[k], 32'h2000_0010 + 32'(4 * k));
      chk("lwr_wdata", log_wdata[k], cpu_wdata[32*k +: 32]);
      chk("lwr_strb",  log_strb[k], 4'hF);
    end

    // Uncached write, request held through its response cycle
    clear_log();
    ack_wait      = 0;
    uncache_waddr = 32'hBFAF_8000;
    uncache_wdata = 32'h1234_5678;
    uncache_wen   = 4'b0011;
    pulses = 0; pulse_cyc = -1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (uncache_write_finish) begin pulses++; pulse_cyc = c; end
      if (c == 3) begin
        chk("uwr_wrdy_c3", dev_wrdy, 1);
        uncache_wen = 4'b0000;
      end
    end
    chk("uwr_fin_cnt", pulses, 1);
    chk("uwr_fin_cyc", pulse_cyc, 2);
    chk("uwr_beats", log_addr.size(), 1);
    if (log_addr.size() > 0) begin
      chk("uwr_addr",  log_addr[0], 32'hBFAF_8000);
      chk("uwr_wdata", log_wdata[0], 32'h1234_5678);
      chk("uwr_strb",  log_strb[0], 4'b0011);
    end

    // Simultaneous line write and line read: write wins, read is dropped
    clear_log();
    cpu_waddr = 32'h4000_0020;
    cpu_wdata = 128'h44444444_33333333_22222222_11111111;
    cpu_raddr = 32'h3000_0000;
    cpu_wen   = 4'hF;
    cpu_ren   = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) begin cpu_wen = 4'h0; cpu_ren = 1'b0; end
      if (dev_rvalid) pulses++;
      if (c == 5) chk("pri_rrdy_c5", dev_rrdy, 1);
    end
    chk("pri_no_rvld", pulses, 0);
    chk("pri_beats", log_addr.size(), 4);
    for (int k = 0; k < 4 && k < log_addr.size(); k++) begin
      chk("pri_addr", log_addr[k], 32'h4000_0020 + 32'(4 * k));
      chk("pri_strb", log_strb[k], 4'hF);
    end
    clear_log();
    cpu_ren = 1'b1;
    pulses = 0; pulse_cyc = -1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) cpu_ren = 1'b0;
      if (dev_rvalid) begin pulses++; pulse_cyc = c; end
      if (c == 5) chk("pri_rdata", dev_rdata, 128'h3000000C_30000008_30000004_30000000);
    end
    chk("pri_rvld_cyc", pulse_cyc, 5);
    chk("pri_rd_beats", log_addr.size(), 4);

    // Uncached read with no ack: timeout after 8 waiting cycles
    clear_log();
    ack_en        = 1'b0;
    uncache_raddr = 32'h1FC0_0004;
    uncache_ren   = 1'b1;
    pulses = 0; pulse_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) uncache_ren = 1'b0;
      if (uncache_rvalid) begin pulses++; pulse_cyc = c; end
      if (c == 8) begin
        chk("tmo_req_c8", mem_req, 1);
        chk("tmo_err_c8", bus_err, 0);
      end
      if (c == 9) begin
        chk("tmo_rdata", uncache_rdata, 32'hDEAD_BEEF);
        chk("tmo_err_c9", bus_err, 1);
        chk("tmo_req_c9", mem_req, 0);
      end
      if (c == 10) chk("tmo_rrdy_c10", dev_rrdy, 1);
    end
    chk("tmo_rvld_cnt", pulses, 1);
    chk("tmo_rvld_cyc", pulse_cyc, 9);

    // bus_err stays set across a later clean uncached read
    ack_en        = 1'b1;
    uncache_raddr = 32'h0000_0100;
    uncache_ren   = 1'b1;
    pulse_cyc = -1;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 1) uncache_ren = 1'b0;
      if (uncache_rvalid) pulse_cyc = c;
    end
    chk("urd_rvld_cyc", pulse_cyc, 2);
    chk("urd_rdata", uncache_rdata, 32'h0000_0100);
    chk("err_sticky", bus_err, 1);

    // Reset during beat 2 of a line read
    clear_log();
    ack_wait  = 1;
    cpu_raddr = 32'h5000_0000;
    cpu_ren   = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) cpu_ren = 1'b0;
    end
    chk("mid_req_before", mem_req, 1);
    chk("mid_beats_before", log_addr.size(), 2);
    rst = 1'b0;
    #1;
    chk("mid_req_async", mem_req, 0);
    step();
    rst = 1'b1;
    pulses = 0; reqcnt = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (dev_rvalid) pulses++;
      if (mem_req) reqcnt++;
    end
    chk("mid_no_rvld", pulses, 0);
    chk("mid_no_req", reqcnt, 0);
    chk("mid_rrdy", dev_rrdy, 1);
    chk("mid_err_clr", bus_err, 0);
    chk("mid_rdata_clr", dev_rdata, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
